// File: rtl/exec_unit_arbiter.sv
// Round-robin arbiter sharing one combinational exec_unit among NUM_REQ requesters,
// with a single registered result stage behind a valid/ready handshake.
module exec_unit_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int TAG_W   = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_pc,
    input  logic [NUM_REQ*32-1:0]  req_rs1,
    input  logic [NUM_REQ*32-1:0]  req_rs2,
    input  logic [NUM_REQ*32-1:0]  req_imm,
    input  logic [NUM_REQ*6-1:0]   req_params,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [31:0]            eu_pc,
    output logic [31:0]            eu_rs1,
    output logic [31:0]            eu_rs2,
    output logic [31:0]            eu_imm,
    output logic [5:0]             eu_params,
    input  logic [31:0]            eu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic [ID_W-1:0]        res_src,
    output logic [TAG_W-1:0]       res_tag,
    output logic [31:0]            op_count
);

    localparam logic       OP1_REG = 1'b0;
    localparam logic       OP2_REG = 1'b0;
    localparam logic [3:0] OP_ADD  = 4'd0;

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    logic              can_acc;
    logic              gnt_found;
    logic              gnt_valid;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   rr_next;
    logic [ID_W:0]     scan_sum;
    logic [TAG_W-1:0]  sel_tag;

    assign can_acc   = !res_valid || res_ready;
    assign gnt_valid = can_acc && gnt_found;
    assign rr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);

    // Scan requesters starting at rr_ptr, wrapping at NUM_REQ-1 back to 0.
    always_comb begin
        gnt_found = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            if (!gnt_found && req_valid[scan_sum[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                grant_idx = scan_sum[ID_W-1:0];
            end
        end
    end

    // Idle exec_unit inputs are forced to a fixed ADD of zeros.
    always_comb begin
        req_ready = '0;
        eu_pc     = '0;
        eu_rs1    = '0;
        eu_rs2    = '0;
        eu_imm    = '0;
        eu_params = {OP1_REG, OP2_REG, OP_ADD};
        sel_tag   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_valid && grant_idx == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                eu_pc        = req_pc[i*32 +: 32];
                eu_rs1       = req_rs1[i*32 +: 32];
                eu_rs2       = req_rs2[i*32 +: 32];
                eu_imm       = req_imm[i*32 +: 32];
                eu_params    = req_params[i*6 +: 6];
                sel_tag      = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_src   <= '0;
            res_tag   <= '0;
            op_count  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (gnt_valid) begin
                res_valid <= 1'b1;
                res_data  <= eu_out;
                res_src   <= grant_idx;
                res_tag   <= sel_tag;
                rr_ptr    <= rr_next;
                op_count  <= op_count + 32'd1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exec_unit_arbiter.sv
// Bench for exec_unit_arbiter: directed vector table, reset sequence, and a
// randomized run against a queue-free round-robin reference model.
module tb_exec_unit_arbiter;

    localparam int N  = 2;
    localparam int TW = 4;

    localparam logic [5:0] P_ADD     = 6'h00;
    localparam logic [5:0] P_SUB     = 6'h01;
    localparam logic [5:0] P_OR      = 6'h03;
    localparam logic [5:0] P_SRA_IMM = 6'h17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_pc, req_rs1, req_rs2, req_imm;
    logic [N*6-1:0]    req_params;
    logic [N*TW-1:0]   req_tag;
    logic [31:0]       eu_pc, eu_rs1, eu_rs2, eu_imm, eu_out;
    logic [5:0]        eu_params;
    logic              res_valid, res_ready;
    logic [31:0]       res_data;
    logic [0:0]        res_src;
    logic [TW-1:0]     res_tag;
    logic [31:0]       op_count;

    logic [31:0]   f_pc[N], f_rs1[N], f_rs2[N], f_imm[N];
    logic [5:0]    f_params[N];
    logic [TW-1:0] f_tag[N];

    int n_tests = 0;
    int n_fail  = 0;

    exec_unit_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_params(req_params), .req_tag(req_tag),
        .eu_pc(eu_pc), .eu_rs1(eu_rs1), .eu_rs2(eu_rs2), .eu_imm(eu_imm),
        .eu_params(eu_params), .eu_out(eu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_src(res_src), .res_tag(res_tag),
        .op_count(op_count)
    );

    // exec_unit: params = {op1_sel(0=rs1,1=pc), op2_sel(0=rs2,1=imm), op[3:0]}
    function automatic logic [31:0] alu(input logic [5:0] p, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [31:0] imm);
        logic [31:0] a, b;
        a = p[5] ? pc : rs1;
        b = p[4] ? imm : rs2;
        case (p[3:0])
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    assign eu_out = alu(eu_params, eu_pc, eu_rs1, eu_rs2, eu_imm);

    always_comb begin
        req_pc = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        req_params = '0; req_tag = '0;
        for (int i = 0; i < N; i++) begin
            req_pc[i*32 +: 32]   = f_pc[i];
            req_rs1[i*32 +: 32]  = f_rs1[i];
            req_rs2[i*32 +: 32]  = f_rs2[i];
            req_imm[i*32 +: 32]  = f_imm[i];
            req_params[i*6 +: 6] = f_params[i];
            req_tag[i*TW +: TW]  = f_tag[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid requester at or after rr, wrapping; -1 if none or blocked.
    function automatic int model_grant(input logic [N-1:0] vld, input bit can, input int rr);
        if (!can) return -1;
        for (int k = 0; k < N; k++) begin
            if (vld[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    typedef struct packed {
        logic [1:0]  vld;
        logic        rdy;
        logic [5:0]  p0;
        logic [31:0] a0, b0;
        logic [3:0]  t0;
        logic [5:0]  p1;
        logic [31:0] a1, b1;
        logic [3:0]  t1;
        logic [1:0]  e_rdy;
        logic        e_rv;
        logic [31:0] e_data;
        logic [31:0] e_src;
        logic [3:0]  e_tag;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    logic [3:0]  m_tag;
    logic [31:0] m_cnt;
    int          m_rr;
    logic [N-1:0] acc;
    int          wait_cnt[N];
    int          max_wait;

    initial begin
        for (int i = 0; i < N; i++) begin
            f_pc[i] = 32'h100 * (i + 1); f_rs1[i] = '0; f_rs2[i] = '0; f_imm[i] = '0;
            f_params[i] = '0; f_tag[i] = '0;
        end
        req_valid = '0;
        res_ready = 1'b0;

        vt[0]  = '{2'b01, 1'b1, P_ADD, 32'd5,  32'd7,  4'd3, P_ADD, 32'h0,  32'h0,  4'd0, 2'b01, 1'b1, 32'd12, 32'd0, 4'd3, 32'd1};
        vt[1]  = '{2'b11, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b10, 1'b1, 32'hFF, 32'd1, 4'd2, 32'd2};
        vt[2]  = '{2'b11, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b01, 1'b1, 32'd6,  32'd0, 4'd1, 32'd3};
        vt[3]  = '{2'b11, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b10, 1'b1, 32'hFF, 32'd1, 4'd2, 32'd4};
        vt[4]  = '{2'b11, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b01, 1'b1, 32'd6,  32'd0, 4'd1, 32'd5};
        vt[5]  = '{2'b11, 1'b0, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b00, 1'b1, 32'd6,  32'd0, 4'd1, 32'd5};
        vt[6]  = '{2'b11, 1'b0, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b00, 1'b1, 32'd6,  32'd0, 4'd1, 32'd5};
        vt[7]  = '{2'b11, 1'b0, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b00, 1'b1, 32'd6,  32'd0, 4'd1, 32'd5};
        vt[8]  = '{2'b11, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b10, 1'b1, 32'hFF, 32'd1, 4'd2, 32'd6};
        vt[9]  = '{2'b11, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b01, 1'b1, 32'd6,  32'd0, 4'd1, 32'd7};
        vt[10] = '{2'b10, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_SRA_IMM, 32'h80000000, 32'd4, 4'd5, 2'b10, 1'b1, 32'hF8000000, 32'd1, 4'd5, 32'd8};
        vt[11] = '{2'b11, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b01, 1'b1, 32'd6,  32'd0, 4'd1, 32'd9};
        vt[12] = '{2'b00, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b00, 1'b0, 32'd0,  32'd0, 4'd0, 32'd9};
        vt[13] = '{2'b00, 1'b0, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b00, 1'b0, 32'd0,  32'd0, 4'd0, 32'd9};
        vt[14] = '{2'b11, 1'b0, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b10, 1'b1, 32'hFF, 32'd1, 4'd2, 32'd10};
        vt[15] = '{2'b11, 1'b0, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b00, 1'b1, 32'hFF, 32'd1, 4'd2, 32'd10};
        vt[16] = '{2'b01, 1'b1, P_SUB, 32'd10, 32'd4,  4'd1, P_OR,  32'hF0, 32'h0F, 4'd2, 2'b01, 1'b1, 32'd6,  32'd0, 4'd1, 32'd11};

        // Reset values
        #3;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  res_data, 32'd0);
        chk("rst_res_src",   32'(res_src), 32'd0);
        chk("rst_res_tag",   32'(res_tag), 32'd0);
        chk("rst_op_count",  op_count, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table
        for (int v = 0; v < NV; v++) begin
            req_valid   = vt[v].vld;
            res_ready   = vt[v].rdy;
            f_params[0] = vt[v].p0; f_rs1[0] = vt[v].a0; f_rs2[0] = vt[v].b0; f_imm[0] = vt[v].b0; f_tag[0] = vt[v].t0;
            f_params[1] = vt[v].p1; f_rs1[1] = vt[v].a1; f_rs2[1] = vt[v].b1; f_imm[1] = vt[v].b1; f_tag[1] = vt[v].t1;
            @(negedge clk);
            chk($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(vt[v].e_rdy));
            chk($sformatf("vec%0d_eu_params", v), 32'(eu_params),
                vt[v].e_rdy[0] ? 32'(vt[v].p0) : vt[v].e_rdy[1] ? 32'(vt[v].p1) : 32'd0);
            chk($sformatf("vec%0d_eu_rs1", v), eu_rs1,
                vt[v].e_rdy[0] ? vt[v].a0 : vt[v].e_rdy[1] ? vt[v].a1 : 32'd0);
            chk($sformatf("vec%0d_eu_imm", v), eu_imm,
                vt[v].e_rdy[0] ? vt[v].b0 : vt[v].e_rdy[1] ? vt[v].b1 : 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_res_valid", v), 32'(res_valid), 32'(vt[v].e_rv));
            if (vt[v].e_rv) begin
                chk($sformatf("vec%0d_res_data", v), res_data, vt[v].e_data);
                chk($sformatf("vec%0d_res_src", v), 32'(res_src), vt[v].e_src);
                chk($sformatf("vec%0d_res_tag", v), 32'(res_tag), 32'(vt[v].e_tag));
            end
            chk($sformatf("vec%0d_op_count", v), op_count, vt[v].e_cnt);
        end

        // Async reset while a result is held and the stage is stalled
        req_valid = 2'b11;
        res_ready = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_res_valid", 32'(res_valid), 32'd0);
        chk("async_rst_op_count",  op_count, 32'd0);
        chk("async_rst_res_data",  res_data, 32'd0);
        chk("async_rst_res_tag",   32'(res_tag), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        chk("post_rst_res_valid", 32'(res_valid), 32'd1);
        chk("post_rst_res_src",   32'(res_src), 32'd0);
        chk("post_rst_res_data",  res_data, 32'd6);
        chk("post_rst_op_count",  op_count, 32'd1);

        // Randomized run against the reference model
        req_valid = '0;
        res_ready = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; m_data = '0; m_src = 0; m_tag = '0; m_cnt = '0; m_rr = 0;
        acc = '0; max_wait = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            int g;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc[i]) begin
                    if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(9) < 6);
                    f_pc[i]     = $urandom;
                    f_rs1[i]    = $urandom;
                    f_rs2[i]    = $urandom;
                    f_imm[i]    = $urandom;
                    f_params[i] = {2'($urandom_range(3)), 1'b0, 3'($urandom_range(7))};
                    f_tag[i]    = 4'($urandom_range(15));
                end
            end
            res_ready = ($urandom_range(9) < 7);

            @(negedge clk);
            g = model_grant(req_valid, !m_valid || res_ready, m_rr);
            chk("rnd_req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
            chk("rnd_eu_params", 32'(eu_params), (g < 0) ? 32'd0 : 32'(f_params[g]));
            chk("rnd_eu_pc",  eu_pc,  (g < 0) ? 32'd0 : f_pc[g]);
            chk("rnd_eu_rs1", eu_rs1, (g < 0) ? 32'd0 : f_rs1[g]);
            chk("rnd_eu_rs2", eu_rs2, (g < 0) ? 32'd0 : f_rs2[g]);
            chk("rnd_eu_imm", eu_imm, (g < 0) ? 32'd0 : f_imm[g]);

            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == g) wait_cnt[i] = 0;
                else if (g >= 0) wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end

            @(posedge clk);
            acc = '0;
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = alu(f_params[g], f_pc[g], f_rs1[g], f_rs2[g], f_imm[g]);
                m_src   = g;
                m_tag   = f_tag[g];
                m_rr    = (g + 1) % N;
                m_cnt   = m_cnt + 32'd1;
                acc[g]  = 1'b1;
            end else if (res_ready) begin
                m_valid = 1'b0;
            end
            #1;
            chk("rnd_res_valid", 32'(res_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rnd_res_data", res_data, m_data);
                chk("rnd_res_src",  32'(res_src), 32'(m_src));
                chk("rnd_res_tag",  32'(res_tag), 32'(m_tag));
            end
            chk("rnd_op_count", op_count, m_cnt);
        end
        chk("rnd_max_wait_within_bound", 32'(max_wait <= N - 1), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
